// File: rtl/sum4_pkg.sv
// Shared width and bitwise generate/propagate helpers for the sum4 adder and
// the second-level lookahead unit built from cla4_logic.
package sum4_pkg;

  localparam int unsigned SUM4_W = 4;

  function automatic logic [SUM4_W-1:0] gen_bits(input logic [SUM4_W-1:0] a,
                                                 input logic [SUM4_W-1:0] b);
    return a & b;
  endfunction

  // XOR propagate so the same term doubles as the half-sum for S.
  function automatic logic [SUM4_W-1:0] prop_bits(input logic [SUM4_W-1:0] a,
                                                  input logic [SUM4_W-1:0] b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/cla4_logic.sv
// Purely combinational 4-bit lookahead unit: flat sum-of-products carries plus group P/G.
// Also usable as the second-level unit when cascading four adders.
module cla4_logic
  import sum4_pkg::*;
(
  input  logic [SUM4_W-1:0] p,
  input  logic [SUM4_W-1:0] g,
  input  logic              c0,
  output logic [SUM4_W:1]   c,
  output logic              P_grp,
  output logic              G_grp
);

  // Every carry is built directly from p/g/c0; no carry feeds the next one.
  assign c[1] = g[0] | (p[0] & c0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);

  assign P_grp = &p;
  assign G_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

  assign c[4] = G_grp | (P_grp & c0);

endmodule

// File: rtl/sum4.sv
// 4-bit carry-lookahead adder with a single registered output stage and
// asynchronous active-low clear.
module sum4
  import sum4_pkg::*;
(
  output logic [SUM4_W-1:0] S,
  output logic              C_out,
  input  logic [SUM4_W-1:0] A,
  input  logic [SUM4_W-1:0] B,
  input  logic              c_in,
  input  logic              clk,
  input  logic              rst_n,
  output logic              P_grp,
  output logic              G_grp
);

  logic [SUM4_W-1:0] g;
  logic [SUM4_W-1:0] p;
  logic [SUM4_W:1]   c;
  logic              p_grp_d;
  logic              g_grp_d;
  logic [SUM4_W-1:0] s_d;

  assign g = gen_bits(A, B);
  assign p = prop_bits(A, B);

  cla4_logic u_cla (
    .p     (p),
    .g     (g),
    .c0    (c_in),
    .c     (c),
    .P_grp (p_grp_d),
    .G_grp (g_grp_d)
  );

  assign s_d = p ^ {c[SUM4_W-1:1], c_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S     <= '0;
      C_out <= 1'b0;
      P_grp <= 1'b0;
      G_grp <= 1'b0;
    end else begin
      S     <= s_d;
      C_out <= c[SUM4_W];
      P_grp <= p_grp_d;
      G_grp <= g_grp_d;
    end
  end

endmodule

// File: tb/tb_sum4.sv
// Scoreboard bench for sum4: expected {C_out,S,P_grp,G_grp} queued at drive time,
// popped one edge later.
module tb_sum4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       c_in;
  logic [3:0] S;
  logic       C_out;
  logic       P_grp;
  logic       G_grp;
  logic [6:0] obs;

  int total = 0;
  int bad   = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  assign obs = {C_out, S, P_grp, G_grp};

  sum4 dut (
    .S     (S),
    .C_out (C_out),
    .A     (A),
    .B     (B),
    .c_in  (c_in),
    .clk   (clk),
    .rst_n (rst_n),
    .P_grp (P_grp),
    .G_grp (G_grp)
  );

  // Reference: arithmetic sum; group generate is the carry-out with no carry-in.
  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic ci);
    logic [4:0] sum;
    logic [4:0] sum_nc;
    sum    = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    sum_nc = {1'b0, a} + {1'b0, b};
    return {sum, (a ^ b) == 4'hF, sum_nc > 5'd15};
  endfunction

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic ci);
    @(negedge clk);
    A    = a;
    B    = b;
    c_in = ci;
    exp_q.push_back(model(a, b, ci));
  endtask

  task automatic test_reset();
    logic [6:0] e;
    rst_n = 1'b0;
    A = 4'hF; B = 4'hF; c_in = 1'b1;
    #2;
    total++;
    if (obs !== 7'b0) begin
      bad++;
      $display("FAIL power_on_reset obs=%b exp=%b", obs, 7'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'hF, 4'hF, 1'b0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL pre_reset_load obs=%b exp=%b", obs, e);
    end
    // Clear in the middle of a cycle, away from any edge.
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 7'b0) begin
      bad++;
      $display("FAIL async_clear obs=%b exp=%b", obs, 7'b0);
    end
    @(posedge clk); #1;
    total++;
    if (obs !== 7'b0) begin
      bad++;
      $display("FAIL reset_hold obs=%b exp=%b", obs, 7'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'hF, 4'hF, 1'b1);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL reset_release obs=%b exp=%b", obs, e);
    end
  endtask

  task automatic test_directed();
    logic [8:0] vec[6];
    logic [6:0] e;
    vec[0] = {4'h0, 4'h0, 1'b1};
    vec[1] = {4'hF, 4'h1, 1'b0};
    vec[2] = {4'hF, 4'hF, 1'b1};
    vec[3] = {4'h0, 4'hF, 1'b1};
    vec[4] = {4'h5, 4'hA, 1'b0};
    vec[5] = {4'h5, 4'hA, 1'b1};
    for (int i = 0; i < 6; i++) begin
      apply(vec[i][8:5], vec[i][4:1], vec[i][0]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL directed_%0d A=%h B=%h cin=%b obs=%b exp=%b", i, vec[i][8:5],
                 vec[i][4:1], vec[i][0], obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] v;
    logic [6:0] e;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      apply(v[8:5], v[4:1], v[0]);
      @(posedge clk); #1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sweep_%0d scoreboard empty obs=%b", i, obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          bad++;
          $display("FAIL sweep_%0d A=%h B=%h cin=%b obs=%b exp=%b", i, v[8:5], v[4:1], v[0],
                   obs, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
